// File: rtl/con_host_link.sv
// con_host_link
// Host-side bridge between an upstream beat stream and a chip that shares a
// three-word bidirectional con bus with the host.
//  - tx path: a one-beat holding register drives con_1..3 with con_valid and
//    con_ready as handshake. The bus is released (high-Z) combinationally
//    the moment the chip claims it with driving_cons.
//  - rx path: results the chip places on the bus, qualified by output_valid,
//    are captured with their coordinates into an RX_DEPTH-entry FIFO.
//  - control: start_req is turned into a single start pulse; busy summarises
//    pending work.
// Ports:
//  clk, rst_in                       clock and synchronous active-high reset
//  tx_valid/tx_ready/tx_data_1..3    upstream beat input
//  con_1..3, con_valid, con_ready    chip-side bus and handshake
//  driving_cons, output_valid,
//  output_x/y/ch                     chip bus ownership and result strobe
//  rx_valid/rx_ready/rx_data_1..3,
//  rx_x/rx_y/rx_ch                   downstream result stream
//  rx_overflow                       sticky: a capture was dropped on full FIFO
//  start_req/start, running, busy    run control
module con_host_link #(
  parameter int IO_DATA_WIDTH      = 16,
  parameter int FEATURE_MAP_WIDTH  = 1024,
  parameter int FEATURE_MAP_HEIGHT = 1024,
  parameter int OUTPUT_NB_CHANNELS = 64,
  parameter int RX_DEPTH           = 4,
  localparam int X_W  = $clog2(FEATURE_MAP_WIDTH),
  localparam int Y_W  = $clog2(FEATURE_MAP_HEIGHT),
  localparam int CH_W = $clog2(OUTPUT_NB_CHANNELS)
) (
  input  logic                     clk,
  input  logic                     rst_in,
  input  logic                     tx_valid,
  output logic                     tx_ready,
  input  logic [IO_DATA_WIDTH-1:0] tx_data_1,
  input  logic [IO_DATA_WIDTH-1:0] tx_data_2,
  input  logic [IO_DATA_WIDTH-1:0] tx_data_3,
  inout  wire  [IO_DATA_WIDTH-1:0] con_1,
  inout  wire  [IO_DATA_WIDTH-1:0] con_2,
  inout  wire  [IO_DATA_WIDTH-1:0] con_3,
  output logic                     con_valid,
  input  logic                     con_ready,
  input  logic                     driving_cons,
  input  logic                     output_valid,
  input  logic [X_W-1:0]           output_x,
  input  logic [Y_W-1:0]           output_y,
  input  logic [CH_W-1:0]          output_ch,
  output logic                     rx_valid,
  input  logic                     rx_ready,
  output logic [IO_DATA_WIDTH-1:0] rx_data_1,
  output logic [IO_DATA_WIDTH-1:0] rx_data_2,
  output logic [IO_DATA_WIDTH-1:0] rx_data_3,
  output logic [X_W-1:0]           rx_x,
  output logic [Y_W-1:0]           rx_y,
  output logic [CH_W-1:0]          rx_ch,
  output logic                     rx_overflow,
  input  logic                     start_req,
  output logic                     start,
  input  logic                     running,
  output logic                     busy
);

  localparam int PTR_W = $clog2(RX_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int ENT_W = 3 * IO_DATA_WIDTH + X_W + Y_W + CH_W;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRIVE = 2'd1,
    ST_YIELD = 2'd2,
    ST_TURN  = 2'd3
  } state_t;

  state_t                   state_r;
  state_t                   state_next_s;
  logic                     hold_valid_r;
  logic [IO_DATA_WIDTH-1:0] hold_1_r;
  logic [IO_DATA_WIDTH-1:0] hold_2_r;
  logic [IO_DATA_WIDTH-1:0] hold_3_r;
  logic                     con_valid_s;
  logic                     con_fire_s;
  logic                     tx_ready_s;
  logic                     accept_s;

  logic [ENT_W-1:0]         mem_r [RX_DEPTH];
  logic [PTR_W-1:0]         wr_ptr_r;
  logic [PTR_W-1:0]         rd_ptr_r;
  logic [CNT_W-1:0]         count_r;
  logic                     overflow_r;
  logic                     empty_s;
  logic                     full_s;
  logic                     rx_valid_s;
  logic                     push_s;
  logic                     pop_s;
  logic                     push_ok_s;
  logic [ENT_W-1:0]         push_entry_s;
  logic [ENT_W-1:0]         head_s;

  logic                     start_r;
  logic                     start_req_d_r;

  // The host may only present a beat in DRIVE, and drops off the bus in the
  // very cycle the chip claims it so the two never contend.
  assign con_valid_s = !rst_in && (state_r == ST_DRIVE) && hold_valid_r && !driving_cons;
  assign con_fire_s  = con_valid_s && con_ready;
  // A beat leaving on this edge frees the register for the next one (no bubble).
  assign tx_ready_s  = !rst_in && (!hold_valid_r || con_fire_s);
  assign accept_s    = tx_valid && tx_ready_s;

  assign con_valid = con_valid_s;
  assign tx_ready  = tx_ready_s;
  assign con_1     = con_valid_s ? hold_1_r : {IO_DATA_WIDTH{1'bz}};
  assign con_2     = con_valid_s ? hold_2_r : {IO_DATA_WIDTH{1'bz}};
  assign con_3     = con_valid_s ? hold_3_r : {IO_DATA_WIDTH{1'bz}};

  // Bus ownership state register.
  always_ff @(posedge clk) begin
    if (rst_in) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state logic: chip ownership always wins; after the chip lets go the
  // bus stays quiet for one TURN cycle before the host drives again.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (driving_cons) begin
          state_next_s = ST_YIELD;
        end else if (accept_s) begin
          state_next_s = ST_DRIVE;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_DRIVE: begin
        if (driving_cons) begin
          state_next_s = ST_YIELD;
        end else if (con_fire_s && !accept_s) begin
          state_next_s = ST_IDLE;
        end else begin
          state_next_s = ST_DRIVE;
        end
      end
      ST_YIELD: begin
        if (!driving_cons) begin
          state_next_s = ST_TURN;
        end else begin
          state_next_s = ST_YIELD;
        end
      end
      ST_TURN: begin
        if (driving_cons) begin
          state_next_s = ST_YIELD;
        end else if (hold_valid_r || accept_s) begin
          state_next_s = ST_DRIVE;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      default: begin
        state_next_s = ST_IDLE;
      end
    endcase
  end

  // One-beat tx holding register; a beat survives chip preemption untouched.
  always_ff @(posedge clk) begin
    if (rst_in) begin
      hold_valid_r <= 1'b0;
      hold_1_r     <= {IO_DATA_WIDTH{1'b0}};
      hold_2_r     <= {IO_DATA_WIDTH{1'b0}};
      hold_3_r     <= {IO_DATA_WIDTH{1'b0}};
    end else if (accept_s) begin
      hold_valid_r <= 1'b1;
      hold_1_r     <= tx_data_1;
      hold_2_r     <= tx_data_2;
      hold_3_r     <= tx_data_3;
    end else if (con_fire_s) begin
      hold_valid_r <= 1'b0;
    end else begin
      hold_valid_r <= hold_valid_r;
    end
  end

  assign empty_s      = (count_r == CNT_W'(0));
  assign full_s       = (count_r == CNT_W'(RX_DEPTH));
  assign rx_valid_s   = !rst_in && !empty_s;
  assign pop_s        = rx_valid_s && rx_ready;
  assign push_s       = !rst_in && driving_cons && output_valid;
  // A pop on the same edge makes room, so a full FIFO still takes the push.
  assign push_ok_s    = push_s && (!full_s || pop_s);
  assign push_entry_s = {con_1, con_2, con_3, output_x, output_y, output_ch};
  assign head_s       = mem_r[rd_ptr_r];

  assign rx_valid    = rx_valid_s;
  assign rx_data_1   = head_s[ENT_W-1 -: IO_DATA_WIDTH];
  assign rx_data_2   = head_s[ENT_W-IO_DATA_WIDTH-1 -: IO_DATA_WIDTH];
  assign rx_data_3   = head_s[X_W+Y_W+CH_W +: IO_DATA_WIDTH];
  assign rx_x        = head_s[Y_W+CH_W +: X_W];
  assign rx_y        = head_s[CH_W +: Y_W];
  assign rx_ch       = head_s[0 +: CH_W];
  assign rx_overflow = overflow_r;

  // Rx FIFO storage; contents are only meaningful under the count.
  always_ff @(posedge clk) begin
    if (push_ok_s) begin
      mem_r[wr_ptr_r] <= push_entry_s;
    end
  end

  // Rx FIFO pointers, occupancy and sticky overflow flag.
  always_ff @(posedge clk) begin
    if (rst_in) begin
      wr_ptr_r   <= PTR_W'(0);
      rd_ptr_r   <= PTR_W'(0);
      count_r    <= CNT_W'(0);
      overflow_r <= 1'b0;
    end else begin
      if (push_ok_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end
      case ({push_ok_s, pop_s})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
      if (push_s && !push_ok_s) begin
        overflow_r <= 1'b1;
      end
    end
  end

  // Start pulse: one per rising edge of start_req, suppressed while running.
  always_ff @(posedge clk) begin
    if (rst_in) begin
      start_r       <= 1'b0;
      start_req_d_r <= 1'b0;
    end else begin
      start_r       <= start_req && !start_req_d_r && !running && !start_r;
      start_req_d_r <= start_req;
    end
  end

  assign start = start_r;
  assign busy  = running || (!rst_in && (hold_valid_r || !empty_s));

endmodule

// File: tb/tb_con_host_link.sv
// Testbench for con_host_link: directed scenarios (tx burst, preemption,
// rx capture, overflow, start control, reset mid-transfer), a behavioural
// model checked every cycle on the falling edge, and literal spot checks.
module tb_con_host_link;

  localparam int W     = 16;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          rst_in;
  logic          tx_valid;
  logic          tx_ready;
  logic [W-1:0]  tx_data_1, tx_data_2, tx_data_3;
  wire  [W-1:0]  con_1, con_2, con_3;
  logic          con_valid;
  logic          con_ready;
  logic          driving_cons;
  logic          output_valid;
  logic [9:0]    output_x, output_y;
  logic [5:0]    output_ch;
  logic          rx_valid;
  logic          rx_ready;
  logic [W-1:0]  rx_data_1, rx_data_2, rx_data_3;
  logic [9:0]    rx_x, rx_y;
  logic [5:0]    rx_ch;
  logic          rx_overflow;
  logic          start_req;
  logic          start;
  logic          running;
  logic          busy;
  logic [W-1:0]  chip_1, chip_2, chip_3;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  // The chip side drives the bus whenever it owns it; otherwise it floats
  // and the pull-ups make an undriven bus read as all ones.
  assign con_1 = driving_cons ? chip_1 : {W{1'bz}};
  assign con_2 = driving_cons ? chip_2 : {W{1'bz}};
  assign con_3 = driving_cons ? chip_3 : {W{1'bz}};
  pullup pu_1 (con_1);
  pullup pu_2 (con_2);
  pullup pu_3 (con_3);

  con_host_link #(.IO_DATA_WIDTH(W), .RX_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_in(rst_in),
    .tx_valid(tx_valid), .tx_ready(tx_ready),
    .tx_data_1(tx_data_1), .tx_data_2(tx_data_2), .tx_data_3(tx_data_3),
    .con_1(con_1), .con_2(con_2), .con_3(con_3),
    .con_valid(con_valid), .con_ready(con_ready),
    .driving_cons(driving_cons), .output_valid(output_valid),
    .output_x(output_x), .output_y(output_y), .output_ch(output_ch),
    .rx_valid(rx_valid), .rx_ready(rx_ready),
    .rx_data_1(rx_data_1), .rx_data_2(rx_data_2), .rx_data_3(rx_data_3),
    .rx_x(rx_x), .rx_y(rx_y), .rx_ch(rx_ch),
    .rx_overflow(rx_overflow),
    .start_req(start_req), .start(start), .running(running), .busy(busy)
  );

  task automatic chk(input string name, input logic [47:0] act, input logic [47:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- behavioural model ----------------
  typedef struct packed {
    logic [W-1:0] d1, d2, d3;
    logic [9:0]   x, y;
    logic [5:0]   ch;
  } rx_t;

  rx_t          rxq[$];
  logic         m_hold_v = 1'b0;
  logic [47:0]  m_hold = 48'h0;
  logic         m_dc1 = 1'b0;   // driving_cons at the last edge
  logic         m_dc2 = 1'b0;   // driving_cons at the edge before that
  logic         m_ovf = 1'b0;
  logic         m_start = 1'b0;
  logic         m_req_d = 1'b0;
  logic         chk_en = 1'b0;
  logic [15:0]  sent_log[$];
  int           start_cnt = 0;

  // The host may drive only once the chip has been off the bus for the
  // current cycle and the two previous edges (yield + turnaround).
  always @(posedge clk) begin
    logic cv_now;
    logic fire_now;
    rx_t  e;
    if (rst_in) begin
      m_hold_v = 1'b0;
      m_hold   = 48'h0;
      m_dc1    = 1'b0;
      m_dc2    = 1'b0;
      rxq.delete();
      m_ovf    = 1'b0;
      m_start  = 1'b0;
      m_req_d  = 1'b0;
      chk_en   = 1'b1;
    end else begin
      cv_now   = m_hold_v && !driving_cons && !m_dc1 && !m_dc2;
      fire_now = cv_now && con_ready;
      if (tx_valid && (!m_hold_v || fire_now)) begin
        m_hold_v = 1'b1;
        m_hold   = {tx_data_1, tx_data_2, tx_data_3};
      end else if (fire_now) begin
        m_hold_v = 1'b0;
      end
      m_dc2 = m_dc1;
      m_dc1 = driving_cons;
      if (rxq.size() > 0 && rx_ready) void'(rxq.pop_front());
      if (driving_cons && output_valid) begin
        e = '{chip_1, chip_2, chip_3, output_x, output_y, output_ch};
        if (rxq.size() < DEPTH) rxq.push_back(e);
        else m_ovf = 1'b1;
      end
      m_start = start_req && !m_req_d && !running && !m_start;
      m_req_d = start_req;
    end
  end

  // Every-cycle comparison of all outputs against the model.
  always @(negedge clk) begin
    logic        e_cv;
    logic        e_rdy;
    logic [47:0] e_bus;
    if (chk_en) begin
      e_cv  = !rst_in && m_hold_v && !driving_cons && !m_dc1 && !m_dc2;
      e_rdy = !rst_in && (!m_hold_v || (e_cv && con_ready));
      e_bus = e_cv ? m_hold : (driving_cons ? {chip_1, chip_2, chip_3} : {48{1'b1}});
      chk("con_valid", 48'(con_valid), 48'(e_cv));
      chk("tx_ready", 48'(tx_ready), 48'(e_rdy));
      chk("con_bus", {con_1, con_2, con_3}, e_bus);
      chk("rx_valid", 48'(rx_valid), 48'(!rst_in && rxq.size() > 0));
      if (!rst_in && rxq.size() > 0) begin
        chk("rx_data", {rx_data_1, rx_data_2, rx_data_3}, {rxq[0].d1, rxq[0].d2, rxq[0].d3});
        chk("rx_coord", 48'({rx_x, rx_y, rx_ch}), 48'({rxq[0].x, rxq[0].y, rxq[0].ch}));
      end
      chk("rx_overflow", 48'(rx_overflow), 48'(m_ovf));
      chk("start", 48'(start), 48'(m_start));
      chk("busy", 48'(busy), 48'(running || (!rst_in && (m_hold_v || rxq.size() > 0))));
      if (con_valid && con_ready) sent_log.push_back(con_1);
      if (start) start_cnt++;
    end
  end

  // ---------------- directed stimulus ----------------
  initial begin
    logic [15:0] exp_burst [3];
    logic [15:0] exp_drain [4];
    exp_burst = '{16'h0001, 16'h0002, 16'h0003};
    exp_drain = '{16'h0101, 16'h0102, 16'h0103, 16'h0200};

    rst_in = 1'b1; tx_valid = 1'b0; tx_data_1 = 16'h0; tx_data_2 = 16'h0; tx_data_3 = 16'h0;
    con_ready = 1'b0; driving_cons = 1'b0; output_valid = 1'b0;
    output_x = 10'd0; output_y = 10'd0; output_ch = 6'd0; rx_ready = 1'b0;
    start_req = 1'b0; running = 1'b1;
    chip_1 = 16'h0; chip_2 = 16'h0; chip_3 = 16'h0;

    // Reset state
    tick();
    chk("rst_busy_running", 48'(busy), 48'(1'b1));
    running = 1'b0;
    #1;
    chk("rst_busy_idle", 48'(busy), 48'(1'b0));
    chk("rst_tx_ready", 48'(tx_ready), 48'(1'b0));
    chk("rst_bus_z", 48'(con_1), 48'(16'hffff));
    tick();
    rst_in = 1'b0;
    #1;
    chk("post_rst_tx_ready", 48'(tx_ready), 48'(1'b1));

    // tx burst: three back-to-back beats
    sent_log.delete();
    con_ready = 1'b1;
    tx_valid = 1'b1;
    tx_data_1 = 16'h0001; tx_data_2 = 16'h0001; tx_data_3 = 16'h0001;
    tick();
    chk("burst_first_valid", 48'(con_valid), 48'(1'b1));
    chk("burst_first_data", 48'(con_1), 48'(16'h0001));
    tx_data_1 = 16'h0002; tx_data_2 = 16'h0002; tx_data_3 = 16'h0002;
    tick();
    tx_data_1 = 16'h0003; tx_data_2 = 16'h0003; tx_data_3 = 16'h0003;
    tick();
    tx_valid = 1'b0;
    tick();
    tick();
    chk("burst_count", 48'(sent_log.size()), 48'(3));
    if (sent_log.size() == 3) begin
      for (int i = 0; i < 3; i++) chk("burst_order", 48'(sent_log[i]), 48'(exp_burst[i]));
    end

    // preemption: held beat survives chip ownership and is sent once
    sent_log.delete();
    con_ready = 1'b0;
    tx_valid = 1'b1;
    tx_data_1 = 16'hAAAA; tx_data_2 = 16'hAAAA; tx_data_3 = 16'hAAAA;
    tick();
    tx_valid = 1'b0;
    chk("pre_held_valid", 48'(con_valid), 48'(1'b1));
    tick();
    driving_cons = 1'b1;
    chip_1 = 16'h5555; chip_2 = 16'h6666; chip_3 = 16'h7777;
    con_ready = 1'b1;
    #1;
    chk("pre_same_cycle_cv", 48'(con_valid), 48'(1'b0));
    chk("pre_same_cycle_bus", 48'(con_1), 48'(16'h5555));
    repeat (4) tick();
    driving_cons = 1'b0;
    #1;
    chk("pre_yield_cv", 48'(con_valid), 48'(1'b0));
    chk("pre_yield_bus", 48'(con_1), 48'(16'hffff));
    tick();
    chk("pre_turn_cv", 48'(con_valid), 48'(1'b0));
    chk("pre_turn_bus", 48'(con_1), 48'(16'hffff));
    tick();
    chk("pre_redrive_cv", 48'(con_valid), 48'(1'b1));
    chk("pre_redrive_bus", 48'(con_1), 48'(16'hAAAA));
    tick();
    chk("pre_done_cv", 48'(con_valid), 48'(1'b0));
    chk("pre_sent_once", 48'(sent_log.size()), 48'(1));
    if (sent_log.size() == 1) chk("pre_sent_value", 48'(sent_log[0]), 48'(16'hAAAA));

    // rx capture
    driving_cons = 1'b1;
    chip_1 = 16'h1234; chip_2 = 16'h2345; chip_3 = 16'h3456;
    output_valid = 1'b1; output_x = 10'd5; output_y = 10'd7; output_ch = 6'd3;
    rx_ready = 1'b1;
    tick();
    output_valid = 1'b0;
    chk("cap_valid", 48'(rx_valid), 48'(1'b1));
    chk("cap_data", 48'(rx_data_1), 48'(16'h1234));
    chk("cap_x", 48'(rx_x), 48'(10'd5));
    chk("cap_y", 48'(rx_y), 48'(10'd7));
    chk("cap_ch", 48'(rx_ch), 48'(6'd3));
    tick();
    chk("cap_popped", 48'(rx_valid), 48'(1'b0));

    // overflow: five captures into a four-deep FIFO, then full+pop+push
    rx_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chip_1 = 16'h0100 + 16'(i); chip_2 = 16'h0; chip_3 = 16'h0;
      output_x = 10'(i); output_y = 10'(i + 1); output_ch = 6'(i + 2);
      output_valid = 1'b1;
      tick();
    end
    output_valid = 1'b0;
    chk("ovf_flag", 48'(rx_overflow), 48'(1'b1));
    chk("ovf_head", 48'(rx_data_1), 48'(16'h0100));
    rx_ready = 1'b1;
    output_valid = 1'b1;
    chip_1 = 16'h0200; output_x = 10'd9; output_y = 10'd9; output_ch = 6'd9;
    tick();
    output_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      chk("drain_valid", 48'(rx_valid), 48'(1'b1));
      chk("drain_data", 48'(rx_data_1), 48'(exp_drain[k]));
      tick();
    end
    chk("drain_empty", 48'(rx_valid), 48'(1'b0));
    chk("ovf_sticky", 48'(rx_overflow), 48'(1'b1));
    driving_cons = 1'b0;
    rx_ready = 1'b0;
    tick();

    // start control
    start_cnt = 0;
    start_req = 1'b1;
    tick();
    start_req = 1'b0;
    chk("start_pulse", 48'(start), 48'(1'b1));
    tick();
    chk("start_single", 48'(start), 48'(1'b0));
    start_req = 1'b1;
    repeat (3) tick();
    start_req = 1'b0;
    tick();
    chk("start_held_count", 48'(start_cnt), 48'(2));
    running = 1'b1;
    start_req = 1'b1;
    tick();
    start_req = 1'b0;
    tick();
    chk("start_running_ignored", 48'(start_cnt), 48'(2));
    running = 1'b0;
    tick();

    // reset in the middle of a drive, with data in the FIFO
    driving_cons = 1'b1;
    chip_1 = 16'h0ABC; output_valid = 1'b1;
    tick();
    output_valid = 1'b0;
    driving_cons = 1'b0;
    con_ready = 1'b0;
    tx_valid = 1'b1;
    tx_data_1 = 16'h7777; tx_data_2 = 16'h7778; tx_data_3 = 16'h7779;
    tick();
    tx_valid = 1'b0;
    tick();
    chk("rst_mid_driving", 48'(con_valid), 48'(1'b1));
    chk("rst_mid_fifo", 48'(rx_valid), 48'(1'b1));
    rst_in = 1'b1;
    #1;
    chk("rst_mid_cv", 48'(con_valid), 48'(1'b0));
    chk("rst_mid_bus", {con_1, con_2, con_3}, {48{1'b1}});
    chk("rst_mid_rx", 48'(rx_valid), 48'(1'b0));
    chk("rst_mid_ready", 48'(tx_ready), 48'(1'b0));
    tick();
    rst_in = 1'b0;
    #1;
    chk("rst_after_ready", 48'(tx_ready), 48'(1'b1));
    chk("rst_after_rx", 48'(rx_valid), 48'(1'b0));
    chk("rst_after_cv", 48'(con_valid), 48'(1'b0));
    chk("rst_after_ovf", 48'(rx_overflow), 48'(1'b0));
    tick();
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
